// File: rtl/game_pkg.sv
// Shared constants and types for the frame compositor and its address helpers.
package game_pkg;

    localparam int unsigned FB_W       = 160;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned VRAM_W     = 160;
    localparam int unsigned NUM_LAYERS = 14;
    localparam logic [7:0]  TRANSP     = 8'hE3;

    typedef struct packed {
        logic [9:0] inicio_X;
        logic [9:0] inicio_Y;
        logic [9:0] final_X;
        logic [9:0] final_Y;
    } rect_t;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StLatch,
        StRun,
        StDrain,
        StDone
    } blit_state_t;

endpackage

// File: rtl/blit_addr_gen.sv
// Linear address y*160 + x for a 160-pixel row pitch, built from shifts and adds.
module blit_addr_gen #(
    parameter int unsigned CoordW = 10,
    parameter int unsigned AddrW  = 17
) (
    input  logic [CoordW-1:0] x_i,
    input  logic [CoordW-1:0] y_i,
    output logic [AddrW-1:0]  addr_o
);

    logic [AddrW-1:0] y_ext;

    assign y_ext  = AddrW'(y_i);
    assign addr_o = (y_ext << 7) + (y_ext << 5) + AddrW'(x_i);

endmodule

// File: rtl/layer_blitter.sv
// Per-frame layer compositor: copies each layer's VRAM rectangle into the framebuffer,
// skipping the transparent key and clipping at the framebuffer edge.
module layer_blitter #(
    parameter int unsigned NUM_LAYERS = game_pkg::NUM_LAYERS,
    parameter int unsigned PIX_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic [32:0]      layer,
    input  logic [9:0]       vram_inicio_X,
    input  logic [9:0]       vram_inicio_Y,
    input  logic [9:0]       vram_final_X,
    input  logic [9:0]       vram_final_Y,
    input  logic [9:0]       FB_X,
    input  logic [9:0]       FB_Y,
    output logic [16:0]      vram_addr,
    output logic             vram_rd_en,
    input  logic [PIX_W-1:0] vram_data,
    output logic [14:0]      fb_addr,
    output logic [PIX_W-1:0] fb_data,
    output logic             fb_we,
    output logic             busy,
    output logic             done
);

    import game_pkg::*;

    blit_state_t      state_q;
    logic [32:0]      layer_q;
    rect_t            rect_q;
    logic [9:0]       fb_x_q, fb_y_q;
    logic [9:0]       cx_q, cy_q;
    logic             drain_q;
    logic             rd_en_q;
    logic [16:0]      vram_addr_q;
    logic             busy_q, done_q;

    logic             s1_valid_q;
    logic [10:0]      s1_dx_q, s1_dy_q;
    logic             fb_we_q;
    logic [14:0]      fb_addr_q;
    logic [PIX_W-1:0] fb_data_q;

    logic [10:0]      w, h;
    logic             last_col, last_row, last_layer, empty;
    logic [9:0]       cx_d, cy_d, base_x, base_y, src_x, src_y;
    logic [16:0]      vram_addr_d;
    logic [14:0]      fb_addr_d;

    assign w          = {1'b0, rect_q.final_X} - {1'b0, rect_q.inicio_X} + 11'd1;
    assign h          = {1'b0, rect_q.final_Y} - {1'b0, rect_q.inicio_Y} + 11'd1;
    assign last_col   = ({1'b0, cx_q} == w - 11'd1);
    assign last_row   = ({1'b0, cy_q} == h - 11'd1);
    assign last_layer = (layer_q == 33'(NUM_LAYERS - 1));
    assign empty      = (vram_final_X < vram_inicio_X) || (vram_final_Y < vram_inicio_Y);

    // Next raster position; in LATCH the descriptor inputs are used before they are registered.
    always_comb begin
        cx_d   = '0;
        cy_d   = '0;
        base_x = rect_q.inicio_X;
        base_y = rect_q.inicio_Y;
        if (state_q == StLatch) begin
            base_x = vram_inicio_X;
            base_y = vram_inicio_Y;
        end else if (last_col) begin
            cy_d = cy_q + 10'd1;
        end else begin
            cx_d = cx_q + 10'd1;
            cy_d = cy_q;
        end
    end

    assign src_x = base_x + cx_d;
    assign src_y = base_y + cy_d;

    blit_addr_gen #(
        .CoordW(10),
        .AddrW (17)
    ) u_vram_addr (
        .x_i   (src_x),
        .y_i   (src_y),
        .addr_o(vram_addr_d)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= StIdle;
            layer_q     <= '0;
            rect_q      <= '0;
            fb_x_q      <= '0;
            fb_y_q      <= '0;
            cx_q        <= '0;
            cy_q        <= '0;
            drain_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            vram_addr_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        layer_q <= '0;
                        busy_q  <= 1'b1;
                        state_q <= StSetup;
                    end
                end
                StSetup: state_q <= StLatch;
                StLatch: begin
                    rect_q <= '{inicio_X: vram_inicio_X, inicio_Y: vram_inicio_Y,
                                final_X: vram_final_X, final_Y: vram_final_Y};
                    fb_x_q <= FB_X;
                    fb_y_q <= FB_Y;
                    cx_q   <= '0;
                    cy_q   <= '0;
                    if (empty) begin
                        if (last_layer) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            layer_q <= layer_q + 33'd1;
                            state_q <= StSetup;
                        end
                    end else begin
                        rd_en_q     <= 1'b1;
                        vram_addr_q <= vram_addr_d;
                        state_q     <= StRun;
                    end
                end
                StRun: begin
                    if (last_col && last_row) begin
                        rd_en_q <= 1'b0;
                        drain_q <= 1'b0;
                        state_q <= StDrain;
                    end else begin
                        cx_q        <= cx_d;
                        cy_q        <= cy_d;
                        vram_addr_q <= vram_addr_d;
                    end
                end
                StDrain: begin
                    if (!drain_q) begin
                        drain_q <= 1'b1;
                    end else if (last_layer) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        layer_q <= layer_q + 33'd1;
                        state_q <= StSetup;
                    end
                end
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    blit_addr_gen #(
        .CoordW(11),
        .AddrW (15)
    ) u_fb_addr (
        .x_i   (s1_dx_q),
        .y_i   (s1_dy_q),
        .addr_o(fb_addr_d)
    );

    // Stage 1 travels with the VRAM read; stage 2 lands the pixel one cycle after data returns.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_dx_q    <= '0;
            s1_dy_q    <= '0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_data_q  <= '0;
        end else begin
            s1_valid_q <= rd_en_q;
            s1_dx_q    <= {1'b0, fb_x_q} + {1'b0, cx_q};
            s1_dy_q    <= {1'b0, fb_y_q} + {1'b0, cy_q};
            fb_we_q    <= s1_valid_q && (vram_data != PIX_W'(TRANSP)) &&
                          (s1_dx_q < 11'(FB_W)) && (s1_dy_q < 11'(FB_H));
            if (s1_valid_q) begin
                fb_addr_q <= fb_addr_d;
                fb_data_q <= vram_data;
            end
        end
    end

    assign layer      = layer_q;
    assign vram_addr  = vram_addr_q;
    assign vram_rd_en = rd_en_q;
    assign fb_addr    = fb_addr_q;
    assign fb_data    = fb_data_q;
    assign fb_we      = fb_we_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_layer_blitter.sv
// Directed bench for layer_blitter with three layers, driven by a small descriptor table.
module tb_layer_blitter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [32:0] layer;
    logic [9:0]  vram_inicio_X, vram_inicio_Y, vram_final_X, vram_final_Y, FB_X, FB_Y;
    logic [16:0] vram_addr;
    logic        vram_rd_en;
    logic [7:0]  vram_data;
    logic [14:0] fb_addr;
    logic [7:0]  fb_data;
    logic        fb_we;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [9:0] c_ix[0:3], c_iy[0:3], c_fx[0:3], c_fy[0:3], c_bx[0:3], c_by[0:3];
    logic [1:0] lidx;
    int         mode;

    // Frame statistics gathered by run_frame.
    int wr, e3, rd_l1, we_l1, first_rd, first_wr, t_l1, t_l2, t_done;
    int minx, maxx, miny, maxy;

    always #5 clk = ~clk;

    layer_blitter #(
        .NUM_LAYERS(3),
        .PIX_W     (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .layer        (layer),
        .vram_inicio_X(vram_inicio_X),
        .vram_inicio_Y(vram_inicio_Y),
        .vram_final_X (vram_final_X),
        .vram_final_Y (vram_final_Y),
        .FB_X         (FB_X),
        .FB_Y         (FB_Y),
        .vram_addr    (vram_addr),
        .vram_rd_en   (vram_rd_en),
        .vram_data    (vram_data),
        .fb_addr      (fb_addr),
        .fb_data      (fb_data),
        .fb_we        (fb_we),
        .busy         (busy),
        .done         (done)
    );

    assign lidx          = (layer < 33'd3) ? layer[1:0] : 2'd0;
    assign vram_inicio_X = c_ix[lidx];
    assign vram_inicio_Y = c_iy[lidx];
    assign vram_final_X  = c_fx[lidx];
    assign vram_final_Y  = c_fy[lidx];
    assign FB_X          = c_bx[lidx];
    assign FB_Y          = c_by[lidx];

    // VRAM model: one-cycle read latency; mode 1 makes every odd address transparent.
    always @(posedge clk) begin
        if (mode == 1 && vram_addr[0]) vram_data <= 8'hE3;
        else                           vram_data <= 8'h1F;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_layer(input int l, input int ix, input int iy, input int fx,
                             input int fy, input int bx, input int by);
        c_ix[l] = 10'(ix); c_iy[l] = 10'(iy); c_fx[l] = 10'(fx);
        c_fy[l] = 10'(fy); c_bx[l] = 10'(bx); c_by[l] = 10'(by);
    endtask

    // Pulses start on a falling edge; cycle 0 is the first SETUP cycle.
    task automatic run_frame(input int budget, input int poke_at);
        int n;
        int x, y;
        wr = 0; e3 = 0; rd_l1 = 0; we_l1 = 0; first_rd = -1; first_wr = -1;
        t_l1 = -1; t_l2 = -1; t_done = -1;
        minx = 9999; maxx = -1; miny = 9999; maxy = -1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        check("busy_at_setup", busy, 1);
        while (!done && n < budget) begin
            if (fb_we) begin
                wr++;
                if (first_wr < 0) first_wr = int'(fb_addr);
                if (fb_data == 8'hE3) e3++;
                if (layer == 33'd1) we_l1++;
                x = int'(fb_addr) % 160;
                y = int'(fb_addr) / 160;
                if (x < minx) minx = x;
                if (x > maxx) maxx = x;
                if (y < miny) miny = y;
                if (y > maxy) maxy = y;
            end
            if (vram_rd_en) begin
                if (first_rd < 0) first_rd = int'(vram_addr);
                if (layer == 33'd1) rd_l1++;
            end
            if (layer == 33'd1 && t_l1 < 0) t_l1 = n;
            if (layer == 33'd2 && t_l2 < 0) t_l2 = n;
            start = (n == poke_at) ? 1'b1 : 1'b0;
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (done) t_done = n;
        check("frame_completed", done, 1);
    endtask

    task automatic cfg_basic();
        set_layer(0, 0, 240, 39, 273, 55, 74);
        set_layer(1, 10, 0, 5, 0, 0, 0);
        set_layer(2, 0, 9, 0, 3, 0, 0);
    endtask

    task automatic cfg_degen();
        set_layer(0, 0, 0, 3, 1, 0, 0);
        set_layer(1, 10, 0, 5, 3, 20, 20);
        set_layer(2, 0, 0, 1, 1, 10, 10);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        mode  = 0;
        for (int i = 0; i < 4; i++) set_layer(i, 0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("rst_layer", layer, 0);
        check("rst_vram_addr", vram_addr, 0);
        check("rst_rd_en", vram_rd_en, 0);
        check("rst_fb_addr", fb_addr, 0);
        check("rst_fb_data", fb_data, 0);
        check("rst_fb_we", fb_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset = 1'b1;
        @(negedge clk);

        // Basic copy: 40x34 rect, two empty layers behind it.
        cfg_basic();
        run_frame(3000, -1);
        check("A_first_rd_addr", first_rd, 38400);
        check("A_first_fb_addr", first_wr, 11895);
        check("A_writes", wr, 1360);
        check("A_layer1_at", t_l1, 1364);
        check("A_done_at", t_done, 1368);
        check("A_no_e3", e3, 0);
        @(negedge clk);
        check("A_done_one_cycle", done, 0);
        check("A_idle_busy", busy, 0);

        // Transparency: odd pixels carry the key.
        mode = 1;
        run_frame(3000, -1);
        check("B_writes", wr, 680);
        check("B_no_e3", e3, 0);
        check("B_done_at", t_done, 1368);
        mode = 0;
        @(negedge clk);

        // Clipping at the bottom-right corner.
        set_layer(0, 0, 0, 39, 7, 140, 115);
        run_frame(3000, -1);
        check("C_writes", wr, 100);
        check("C_layer1_at", t_l1, 324);
        check("C_minx", minx, 140);
        check("C_maxx", maxx, 159);
        check("C_miny", miny, 115);
        check("C_maxy", maxy, 119);
        // start during the DONE cycle must not relaunch.
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("C_done_start_ignored", busy, 0);
        @(negedge clk);
        check("C_still_idle", busy, 0);

        // Degenerate layer 1 in a three-layer frame.
        cfg_degen();
        run_frame(500, -1);
        check("D_rd_l1", rd_l1, 0);
        check("D_we_l1", we_l1, 0);
        check("D_layer1_at", t_l1, 12);
        check("D_layer2_at", t_l2, 14);
        check("D_done_at", t_done, 22);
        check("D_writes", wr, 12);
        @(negedge clk);

        // start pulse during RUN is ignored.
        cfg_basic();
        run_frame(3000, 100);
        check("E_writes", wr, 1360);
        check("E_layer1_at", t_l1, 1364);
        check("E_done_at", t_done, 1368);
        @(negedge clk);

        // Reset for one cycle during layer 2 RUN.
        cfg_degen();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!(layer == 33'd2 && vram_rd_en) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("F_reached_layer2_run", (layer == 33'd2 && vram_rd_en) ? 1 : 0, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        check("F_busy", busy, 0);
        check("F_fb_we", fb_we, 0);
        check("F_layer", layer, 0);
        check("F_rd_en", vram_rd_en, 0);
        @(negedge clk);
        check("F_fb_we_after", fb_we, 0);
        check("F_busy_after", busy, 0);
        run_frame(500, -1);
        check("F_rerun_writes", wr, 12);
        check("F_rerun_done_at", t_done, 22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
